// File: rtl/sensor_sampler.sv
// Sensor ADC capture with a framed result word shifted out MSB-first to READ.
// Define SENSOR_AVG_EN to average two back-to-back conversions per capture.
module sensor_sampler #(
    parameter int DATA_W     = 10,
    parameter int SETTLE_CYC = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adc_sample,
    input  logic [2:0]        senscode,
    output logic              conv_start,
    output logic [2:0]        conv_chan,
    input  logic              conv_done,
    input  logic [DATA_W-1:0] conv_data,
    input  logic              adc_sample_ctl,
    input  logic              adc_sample_clk,
    output logic              adc_sample_datain,
    output logic              busy,
    output logic              valid,
    output logic              timeout_err
);

    localparam int W = DATA_W + 6;
    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYC);
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ONES = '1;

    typedef enum logic [2:0] {
        IDLE, SETTLE, CONVERT, GAP, CONVERT2, READY, SHIFT
    } state_t;

    state_t       state;
    logic         samp_q, ctl_q, sclk_q;
    logic         samp_rise, ctl_rise, ctl_fall, sclk_rise;
    logic [W-1:0] word, shifter;
    logic [9:0]   cnt;
    logic         pend;

    assign samp_rise = adc_sample & ~samp_q;
    assign ctl_rise  = adc_sample_ctl & ~ctl_q;
    assign ctl_fall  = ~adc_sample_ctl & ctl_q;
    assign sclk_rise = adc_sample_clk & ~sclk_q;

`ifdef SENSOR_AVG_EN
    logic [DATA_W-1:0] d0;
    logic [DATA_W:0]   sum;
    assign sum = {1'b0, d0} + {1'b0, conv_data};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            samp_q            <= 1'b0;
            ctl_q             <= 1'b0;
            sclk_q            <= 1'b0;
            word              <= '0;
            shifter           <= '0;
            cnt               <= '0;
            pend              <= 1'b0;
            conv_start        <= 1'b0;
            conv_chan         <= '0;
            adc_sample_datain <= 1'b0;
            busy              <= 1'b0;
            valid             <= 1'b0;
            timeout_err       <= 1'b0;
`ifdef SENSOR_AVG_EN
            d0                <= '0;
`endif
        end else begin
            samp_q <= adc_sample;
            ctl_q  <= adc_sample_ctl;
            sclk_q <= adc_sample_clk;
            // A frame opened mid-capture is remembered until busy drops
            if (ctl_fall) pend <= 1'b0;
            else if (ctl_rise && busy) pend <= 1'b1;

            unique case (state)
                IDLE, READY: begin
                    if (ctl_rise || (pend && adc_sample_ctl)) begin
                        state             <= SHIFT;
                        shifter           <= word;
                        adc_sample_datain <= word[W-1];
                        valid             <= 1'b0;
                        pend              <= 1'b0;
                    end else if (samp_rise) begin
                        conv_chan   <= senscode;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        valid       <= 1'b0;
                        cnt         <= '0;
                        state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        conv_start <= 1'b1;
                        cnt        <= '0;
                        state      <= CONVERT;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
`ifdef SENSOR_AVG_EN
                        d0         <= conv_data;
                        conv_start <= 1'b0;
                        state      <= GAP;
`else
                        word       <= {conv_chan, 3'b000, conv_data};
                        conv_start <= 1'b0;
                        busy       <= 1'b0;
                        valid      <= 1'b1;
                        state      <= READY;
`endif
                    end else if (cnt == TO_LAST) begin
                        word        <= {conv_chan, 3'b100, ONES};
                        timeout_err <= 1'b1;
                        conv_start  <= 1'b0;
                        busy        <= 1'b0;
                        valid       <= 1'b1;
                        state       <= READY;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
`ifdef SENSOR_AVG_EN
                GAP: begin
                    conv_start <= 1'b1;
                    cnt        <= '0;
                    state      <= CONVERT2;
                end
                CONVERT2: begin
                    if (conv_done) begin
                        word       <= {conv_chan, 3'b000, sum[DATA_W:1]};
                        conv_start <= 1'b0;
                        busy       <= 1'b0;
                        valid      <= 1'b1;
                        state      <= READY;
                    end else if (cnt == TO_LAST) begin
                        word        <= {conv_chan, 3'b100, ONES};
                        timeout_err <= 1'b1;
                        conv_start  <= 1'b0;
                        busy        <= 1'b0;
                        valid       <= 1'b1;
                        state       <= READY;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
`endif
                SHIFT: begin
                    if (ctl_fall) begin
                        state             <= IDLE;
                        adc_sample_datain <= 1'b0;
                    end else if (sclk_rise) begin
                        shifter           <= {shifter[W-2:0], 1'b0};
                        adc_sample_datain <= shifter[W-2];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sensor_sampler.md
Name: sensor_sampler

Overview:
- Sits downstream of the tag top level.
- Consumes the controller's adc_sample request and the packet-parsed senscode channel select.
- Runs one sensor ADC conversion through a start/done handshake and latches the result as a framed word.
- Serializes that word MSB-first to the READ datapath on adc_sample_ctl / adc_sample_clk, returning bits on adc_sample_datain.

Parameters:
- DATA_W, 10: ADC result width; output word width is DATA_W+6.
- SETTLE_CYC, 8: clk cycles between the adc_sample rising edge and conv_start assertion (analog mux settling).
- TIMEOUT, 255: max clk cycles conv_start may stay high awaiting conv_done; range 1..1023.

Ports:
- clk  input  1  oscillator clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- adc_sample  input  1  sample request level from controller; rising edge starts a capture.
- senscode  input  3  sensor channel select, latched on capture start.
- conv_start  output  1  ADC start request, level, held until done or timeout.
- conv_chan  output  3  channel presented to ADC, stable while busy.
- conv_done  input  1  ADC completion, sampled when conv_start=1.
- conv_data  input  DATA_W  ADC result, valid with conv_done.
- adc_sample_ctl  input  1  READ frame enable.
- adc_sample_clk  input  1  READ bit strobe, synchronous to clk; rising edge advances shifter.
- adc_sample_datain  output  1  serial data to READ, MSB first.
- busy  output  1  capture in progress.
- valid  output  1  framed word holds an unread capture.
- timeout_err  output  1  last capture timed out; sticky until next capture starts.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; word register 0; edge-detect registers 0.
- Edge detection: registered copies of adc_sample, adc_sample_ctl and adc_sample_clk. Rise = cur & ~prev. Fall = ~cur & prev.
- State IDLE/READY: on adc_sample rise
  - latch senscode into conv_chan
  - busy=1, timeout_err=0, valid=0
  - counter=0, go to SETTLE
- State SETTLE: count SETTLE_CYC cycles, then conv_start=1 and go to CONVERT. conv_start is first high exactly SETTLE_CYC+1 cycles after the adc_sample rise is registered.
- State CONVERT, conv_done=1:
  - word = {conv_chan, 1'b0, 2'b00, conv_data}
  - conv_start=0, busy=0, valid=1, go to READY
- State CONVERT, timeout: counter reaches TIMEOUT with no conv_done.
  - word = {conv_chan, 1'b1, 2'b00, all-ones}
  - timeout_err=1, valid=1, conv_start=0, busy=0, go to READY
- conv_done and timeout in the same cycle: conv_done wins.
- adc_sample rise while busy: ignored, no retrigger.
- State SHIFT entry: on adc_sample_ctl rise, from any non-busy state.
  - shifter loaded from word
  - adc_sample_datain = word MSB on the next cycle
  - valid=0
  - a ctl rise while busy is deferred until busy falls, with ctl still high
- State SHIFT operation: each adc_sample_clk rise shifts left one bit, zero-filled. Bits beyond DATA_W+6 read 0.
- State SHIFT exit: adc_sample_ctl fall returns to IDLE and adc_sample_datain=0. The word is retained, so a re-read returns the same word.
- adc_sample rise during SHIFT: ignored.
- conv_done outside CONVERT: ignored.

Optional Feature:
- Macro: SENSOR_AVG_EN.
- Defined: CONVERT performs two back-to-back conversions.
  - conv_start drops for one cycle after the first conv_done, then reasserts.
  - Result = (d0+d1)>>1, using a DATA_W+1 bit sum, truncated.
  - Timeout on either conversion yields the timeout word.
  - TIMEOUT applies per conversion.
- Undefined: single conversion only, with no sum register.

Test Plan:
- Reset, then idle 20 cycles -> all outputs 0, adc_sample_datain=0.
- senscode=3'b101, adc_sample rise, conv_done after 5 cycles with conv_data=10'h2A5 -> conv_start high SETTLE_CYC+1 cycles after the rise; valid=1; word=16'hA2A5; serial read of 16 strobes gives 1010001010100101.
- conv_done never asserted -> conv_start falls after 255 cycles; timeout_err=1; word=16'h{chan,1}3FF pattern (e.g. chan 0 -> 16'h13FF).
- Second adc_sample rise during CONVERT, and ctl rise during SETTLE -> no retrigger; shifting starts only after busy=0; first bit = new word MSB.
- 20 strobes in one frame, then ctl fall and a new frame -> bits 17-20 read 0; the re-read repeats the identical 16 bits.
- With SENSOR_AVG_EN: d0=10'h100, d1=10'h101 -> data field 10'h100; reset asserted mid-CONVERT -> conv_start=0, busy=0 the next cycle.
